// File: rtl/exec_pipe_pkg.sv
// rtl/exec_pipe_pkg.sv - opcodes, default widths and stage-entry type for exec_pipe
package exec_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_REG_AW-1:0] dest;
        logic                  wen;
    } stage_entry_t;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU evaluated in front of pipeline stage 0
module exec_alu
    import exec_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = $signed(a_i) >>> shamt;
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_pipe.sv
// rtl/exec_pipe.sv - elastic execute pipeline with flush, occupancy and optional forwarding (EXEC_PIPE_FWD_EN)
module exec_pipe
    import exec_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 3,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic [REG_AW-1:0]          in_dest,
    input  logic                       in_wen,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [REG_AW-1:0]          out_dest,
    output logic                       out_wen,
    input  logic                       flush,
    input  logic [REG_AW-1:0]          query_reg,
    output logic                       query_hit,
    output logic [DATA_W-1:0]          query_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q, valid_d, adv;
    logic [DATA_W-1:0] res_q  [DEPTH];
    logic [DATA_W-1:0] res_d  [DEPTH];
    logic [REG_AW-1:0] dest_q [DEPTH];
    logic [REG_AW-1:0] dest_d [DEPTH];
    logic [DEPTH-1:0]  wen_q, wen_d;
    logic [DATA_W-1:0] alu_res;
    logic              accept;

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (in_op),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (alu_res)
    );

    // Advance decisions ripple from the retire end back toward stage 0.
    always_comb begin
        logic ok;
        adv = '0;
        ok  = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            adv[i] = valid_q[i] & ok;
            ok     = ~valid_q[i] | adv[i];
        end
    end

    assign in_ready = ~flush & (~valid_q[0] | adv[0]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        logic carry;
        carry     = accept;
        valid_d   = '0;
        res_d[0]  = accept ? alu_res : res_q[0];
        dest_d[0] = accept ? in_dest : dest_q[0];
        wen_d     = wen_q;
        wen_d[0]  = accept ? in_wen  : wen_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = carry | (valid_q[i] & ~adv[i]);
            carry      = adv[i];
        end
        for (int i = 1; i < DEPTH; i++) begin
            res_d[i]  = adv[i-1] ? res_q[i-1]  : res_q[i];
            dest_d[i] = adv[i-1] ? dest_q[i-1] : dest_q[i];
            wen_d[i]  = adv[i-1] ? wen_q[i-1]  : wen_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            wen_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            valid_q <= flush ? '0 : valid_d;
            wen_q   <= wen_d;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= res_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign out_valid  = valid_q[DEPTH-1];
    assign out_result = res_q[DEPTH-1];
    assign out_dest   = dest_q[DEPTH-1];
    assign out_wen    = wen_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

`ifdef EXEC_PIPE_FWD_EN
    // Scan oldest to youngest so the lowest-index match wins.
    always_comb begin
        query_hit  = 1'b0;
        query_data = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid_q[i] && wen_q[i] && (dest_q[i] == query_reg) && (query_reg != '0)) begin
                query_hit  = 1'b1;
                query_data = res_q[i];
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^query_reg;
    assign query_hit    = 1'b0;
    assign query_data   = '0;
`endif

endmodule

// File: tb/tb_exec_pipe.sv
// tb/tb_exec_pipe.sv - randomized and directed self-checking bench for exec_pipe
module tb_exec_pipe;

    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, in_wen, out_valid, out_ready, out_wen, flush, query_hit;
    logic [3:0]    in_op;
    logic [DW-1:0] in_a, in_b, out_result, query_data;
    logic [AW-1:0] in_dest, out_dest, query_reg;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    exec_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_dest(in_dest), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_wen(out_wen), .flush(flush),
        .query_reg(query_reg), .query_hit(query_hit), .query_data(query_data),
        .occupancy(occupancy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic [AW-1:0] dest;
        logic          wen;
        int            pos;
    } ent_t;
    ent_t mq[$];

    bit            d_valid, d_wen, d_ordy, d_flush, d_reset;
    logic [3:0]    d_op;
    logic [DW-1:0] d_a, d_b;
    logic [AW-1:0] d_dest, d_qreg;
    bit            chk_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[DW-1] ? ~({DW{1'b1}} >> sh) : '0);
            4'd8: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Positions are 0..DEPTH-1; DEPTH means retired. Oldest entry decides first.
    function automatic int free_below_youngest(input bit ordy);
        int lim;
        lim = ordy ? DEPTH : DEPTH-1;
        foreach (mq[j]) begin
            int np;
            np  = (mq[j].pos + 1 <= lim) ? mq[j].pos + 1 : mq[j].pos;
            lim = np - 1;
        end
        return lim;
    endfunction

    task automatic idle();
        d_valid = 0; d_op = 0; d_a = 0; d_b = 0; d_dest = 0; d_wen = 0;
        d_flush = 0; d_reset = 0; d_qreg = 0;
    endtask

    task automatic step();
        bit            exp_ready, exp_ov, exp_hit;
        logic [DW-1:0] exp_qd;
        int            lim;
        @(negedge clk);
        reset = d_reset; in_valid = d_valid; in_op = d_op; in_a = d_a; in_b = d_b;
        in_dest = d_dest; in_wen = d_wen; out_ready = d_ordy; flush = d_flush; query_reg = d_qreg;
        #1;
        exp_ready = !d_flush && (free_below_youngest(d_ordy) >= 0);
        exp_ov    = (mq.size() > 0) && (mq[0].pos == DEPTH-1);
        exp_hit   = 0;
        exp_qd    = '0;
`ifdef EXEC_PIPE_FWD_EN
        for (int j = mq.size()-1; j >= 0; j--) begin
            if (!exp_hit && mq[j].wen && mq[j].dest == d_qreg && d_qreg != 0) begin
                exp_hit = 1;
                exp_qd  = mq[j].res;
            end
        end
`endif
        if (chk_en) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("occupancy", occupancy, mq.size());
            chk("query_hit", query_hit, exp_hit);
            chk("query_data", query_data, exp_qd);
            if (exp_ov) begin
                chk("out_result", out_result, mq[0].res);
                chk("out_dest", out_dest, mq[0].dest);
                chk("out_wen", out_wen, mq[0].wen);
            end
        end
        if (d_reset || d_flush) begin
            mq.delete();
        end else begin
            lim = d_ordy ? DEPTH : DEPTH-1;
            foreach (mq[j]) begin
                if (mq[j].pos + 1 <= lim) mq[j].pos = mq[j].pos + 1;
                lim = mq[j].pos - 1;
            end
            while (mq.size() > 0 && mq[0].pos == DEPTH) void'(mq.pop_front());
            if (d_valid && exp_ready) mq.push_back('{alu_ref(d_op, d_a, d_b), d_dest, d_wen, 0});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] dest);
        d_valid = 1; d_op = op; d_a = a; d_b = b; d_dest = dest; d_wen = 1;
        step();
        d_valid = 0;
    endtask

    task automatic run_single(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [DW-1:0] exp_res, input int exp_lat);
        bit seen;
        seen = 0;
        d_ordy = 1;
        issue(op, a, b, 5'd3);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (!seen && out_valid) begin
                seen = 1;
                chk({name, "_result"}, out_result, exp_res);
                chk({name, "_dest"}, out_dest, 3);
                if (exp_lat > 0) chk({name, "_latency"}, k, exp_lat);
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_result"}, out_result, 0);
        chk({name, "_out_dest"}, out_dest, 0);
        chk({name, "_out_wen"}, out_wen, 0);
        chk({name, "_query_hit"}, query_hit, 0);
        chk({name, "_query_data"}, query_data, 0);
        chk({name, "_occupancy"}, occupancy, 0);
    endtask

    initial begin
        int retired;
        idle();
        d_ordy = 1;
        chk_en = 0;
        d_reset = 1;
        step();
        chk_en = 1;
        step();
        reset_checks("reset");
        d_reset = 0;

        chk("alu_sub", alu_ref(4'd1, 0, 1), 32'hFFFF_FFFF);
        chk("alu_sra", alu_ref(4'd7, 32'h8000_0000, 4), 32'hF800_0000);
        chk("alu_slt", alu_ref(4'd8, 32'hFFFF_FFFF, 1), 1);

        d_valid = 1; d_op = 0; d_a = 5; d_b = 7; d_dest = 3; d_wen = 1;
        step();
        chk("ready_after_reset", in_ready, 1);
        d_valid = 0;
        begin
            bit seen;
            seen = 0;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (!seen && out_valid) begin
                    seen = 1;
                    chk("add_latency", k, 3);
                    chk("add_result", out_result, 12);
                    chk("add_dest", out_dest, 3);
                end
            end
            if (!seen) chk("add_timeout", 0, 1);
        end

        d_ordy = 0;
        issue(4'd0, 1, 0, 5'd1);
        issue(4'd0, 2, 0, 5'd2);
        issue(4'd0, 3, 0, 5'd3);
        d_valid = 1;
        step();
        chk("full_occupancy", occupancy, 3);
        chk("full_in_ready", in_ready, 0);
        d_valid = 0;
        d_ordy = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("drain_valid", out_valid, 1);
            chk("drain_order", out_result, k);
        end
        step();
        chk("drain_empty", out_valid, 0);

        run_single("sub", 4'd1, 0, 1, 32'hFFFF_FFFF, 3);
        run_single("sra", 4'd7, 32'h8000_0000, 4, 32'hF800_0000, 0);
        run_single("slt", 4'd8, 32'hFFFF_FFFF, 1, 1, 0);
        run_single("sltu", 4'd9, 32'hFFFF_FFFF, 1, 0, 0);
        run_single("op12", 4'd12, 32'h1234, 32'h5678, 0, 0);

        d_ordy = 0;
        issue(4'd0, 32'hAA, 0, 5'd4);
        issue(4'd0, 32'hBB, 0, 5'd4);
        d_qreg = 4;
        step();
`ifdef EXEC_PIPE_FWD_EN
        chk("fwd_hit", query_hit, 1);
        chk("fwd_data", query_data, 32'hBB);
`else
        chk("fwd_hit_off", query_hit, 0);
        chk("fwd_data_off", query_data, 0);
`endif
        d_qreg = 0;
        step();
        chk("fwd_reg0", query_hit, 0);
        d_ordy = 1;
        repeat (5) step();

        d_ordy = 0;
        issue(4'd0, 1, 1, 5'd1);
        issue(4'd0, 2, 2, 5'd2);
        issue(4'd0, 3, 3, 5'd3);
        d_valid = 1; d_op = 0; d_a = 32'h99; d_b = 0; d_dest = 7; d_wen = 1; d_flush = 1;
        step();
        chk("flush_in_ready", in_ready, 0);
        idle();
        step();
        chk("flush_occupancy", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        d_ordy = 1;
        retired = 0;
        repeat (6) begin
            step();
            if (out_valid) retired++;
        end
        chk("flush_no_retire", retired, 0);

        d_ordy = 0;
        issue(4'd0, 10, 1, 5'd5);
        issue(4'd0, 20, 2, 5'd6);
        d_reset = 1;
        step();
        d_reset = 0;
        d_ordy = 1;
        step();
        reset_checks("midreset");
        chk("midreset_in_ready", in_ready, 1);
        retired = 0;
        repeat (6) begin
            step();
            if (out_valid) retired++;
        end
        chk("midreset_no_retire", retired, 0);

        for (int c = 0; c < 3000; c++) begin
            d_valid = ($urandom_range(0, 9) < 7);
            d_op    = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: d_a = 32'h8000_0000;
                1: d_a = 32'hFFFF_FFFF;
                default: d_a = $urandom;
            endcase
            d_b     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            d_dest  = 5'($urandom_range(0, 7));
            d_wen   = ($urandom_range(0, 3) != 0);
            d_ordy  = ($urandom_range(0, 9) < 7);
            d_flush = ($urandom_range(0, 99) < 3);
            d_reset = ($urandom_range(0, 199) == 0);
            d_qreg  = 5'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_pipe.md
EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 3, number of pipeline stages (legal 1..8).
REQ-003 SHALL have parameter REG_AW, default 5, destination register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the issue handshake.
REQ-007 SHALL have ports in_op input 4 (ALU opcode), plus in_a and in_b, each input DATA_W (operands).
REQ-008 SHALL have ports in_dest input REG_AW and in_wen input 1, destination and write-enable.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the retire handshake.
REQ-010 SHALL have ports out_result output DATA_W, out_dest output REG_AW and out_wen output 1.
REQ-011 SHALL have port flush  input  1  discard all in-flight entries.
REQ-012 SHALL have ports query_reg input REG_AW, query_hit output 1 and query_data output DATA_W (forwarding lookup).
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 SHALL compute the result combinationally from in_op/in_a/in_b and capture it into stage 0 on the accepting edge.
REQ-015 SHALL support opcodes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8 (signed, result 1/0), SLTU=9; codes 10-15 SHALL produce 0.
REQ-016 SHALL use shift amount = in_b[$clog2(DATA_W)-1:0]; ADD/SUB SHALL wrap modulo 2^DATA_W.
REQ-017 SHALL drive out_* from stage DEPTH-1; with out_ready held high, latency SHALL be exactly DEPTH cycles from acceptance to out_valid.
REQ-018 Stage i SHALL advance when valid and (i==DEPTH-1 ? out_ready : stage i+1 empty or advancing).
REQ-019 SHALL drive in_ready = !valid[0] || advance[0], so full throughput is 1 entry/cycle and a full pipe with out_ready low holds all entries unchanged.
REQ-020 Simultaneous accept and retire on a full pipe SHALL occur with no bubble.
REQ-021 flush SHALL clear all valid bits at the next edge, SHALL force in_ready low in that cycle, and SHALL take priority over accept and retire.
REQ-022 query_hit SHALL be 1 when any valid stage has wen=1 and dest==query_reg with query_reg!=0; query_data SHALL come from the youngest such stage (lowest index).
REQ-023 When no hit occurs, query_data SHALL be 0; the query path SHALL be purely combinational.
REQ-024 occupancy SHALL equal the number of set valid bits at all times.

Reset
REQ-025 On reset, all valid bits, stage registers, out_valid, out_result, out_dest, out_wen, query_hit, query_data and occupancy SHALL be 0.
REQ-026 reset SHALL take priority over flush and handshakes; entries in flight at reset SHALL be lost and never retired.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro EXEC_PIPE_FWD_EN SHALL, when defined, implement the query lookup of REQ-022/023.
REQ-029 Without EXEC_PIPE_FWD_EN, query_hit and query_data SHALL be tied to 0; all other behaviour SHALL be unchanged.

Structure
REQ-030 Package exec_pipe_pkg SHALL hold the opcode constants, the default DATA_W/REG_AW, and the stage-entry struct (result, dest, wen).
REQ-031 The opcode evaluation SHALL be a single combinational sub-module named exec_alu, instantiated once in front of stage 0.

Verification
REQ-032 Reset then ADD 5+7 dest=3, out_ready=1 -> out_valid after exactly 3 cycles, out_result=12, out_dest=3.
REQ-033 Issue 3 ops back-to-back with out_ready=0 -> occupancy=3, in_ready=0; raise out_ready -> 3 retires on consecutive cycles, in order, no bubble.
REQ-034 SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0; op 12 -> 0.
REQ-035 Stages hold dest=4 (older, 0xAA) and dest=4 (younger, 0xBB), query_reg=4 -> query_hit=1, query_data=0xBB; query_reg=0 -> query_hit=0.
REQ-036 Pipe full, assert flush together with in_valid=1 -> next cycle occupancy=0 and no out_valid; the flush-cycle input is never retired.
REQ-037 Assert reset mid-stream with 2 entries in flight -> all outputs 0 on the next cycle and the in-flight entries are never retired.
